// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the 8088 bus region controller
package bus_pkg;

   // Upper bound on decoded regions and width of a per-region wait-state count
   localparam int MAX_REGIONS = 8;
   localparam int WS_WIDTH    = 4;
   // Region descriptors hold addresses zero-extended to this width
   localparam int DESC_AW     = 32;

   // Bus cycle phases as seen from the controller
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ADDR   = 2'd1,
      ST_WAIT   = 2'd2,
      ST_ACTIVE = 2'd3
   } state_t;

   // One decoded region: compare base/mask, memory-or-I/O space, wait states
   typedef struct packed {
      logic [DESC_AW-1:0]  base;
      logic [DESC_AW-1:0]  mask;
      logic                io;
      logic [WS_WIDTH-1:0] ws;
   } region_t;

   // A region responds when the masked address bits agree and the space matches
   function automatic logic region_match(input region_t r,
                                         input logic [DESC_AW-1:0] addr,
                                         input logic iom);
      return ((addr & r.mask) == (r.base & r.mask)) && (iom == r.io);
   endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// rtl/bus_wait_counter.sv - loadable wait-state down-counter with done flag
module bus_wait_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_value,
   output logic         done
);

   logic [W-1:0] count;

   // Load takes priority; decrement stops at zero so an idle counter stays put
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   // Done on the last wait clock so READY can be raised on that same edge
   assign done = (count == W'(1));

endmodule

// File: rtl/bus_region_ctrl.sv
// rtl/bus_region_ctrl.sv - 8088 address latch, region decode, wait-state and transceiver control
module bus_region_ctrl
   import bus_pkg::*;
#(
   parameter int NUM_REGIONS = 4,
   parameter int ADDR_WIDTH  = 20,
   parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE =
      {20'h01C00, 20'h0FF00, 20'h80000, 20'h00000},
   parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK =
      {20'h0FE00, 20'h0FFF0, 20'h80000, 20'h80000},
   parameter logic [NUM_REGIONS-1:0] REGION_IO = 4'b1100,
   parameter logic [NUM_REGIONS*WS_WIDTH-1:0] REGION_WS =
      {4'd3, 4'd1, 4'd2, 4'd0}
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   ALE,
   input  logic                   IOM,
   input  logic                   RD,
   input  logic                   WR,
   input  logic                   DTR,
   input  logic                   DEN,
   input  logic [7:0]             AD,
   input  logic [ADDR_WIDTH-9:0]  A,
   output logic [ADDR_WIDTH-1:0]  Address,
   output logic [NUM_REGIONS-1:0] CS,
   output logic                   READY,
   output logic                   XcvrToDev,
   output logic                   XcvrToCpu,
   output logic                   Unmapped,
   output logic [7:0]             ErrCount
);

   state_t                 state;
   state_t                 next_state;

   logic [ADDR_WIDTH-1:0]  addr_q;
   logic                   iom_q;
   logic [NUM_REGIONS-1:0] cs_q;
   logic                   ready_q;
   logic                   unmapped_q;
   logic [7:0]             err_q;

   logic [NUM_REGIONS-1:0] dec_cs;
   logic                   dec_hit;
   logic [WS_WIDTH-1:0]    dec_ws;

   logic                   strobe;
   logic                   latch_addr;
   logic                   capture_dec;
   logic                   cnt_load;
   logic                   cnt_dec;
   logic                   cnt_done;
   logic                   ready_clr;
   logic                   ready_set;
   logic                   err_inc;
   logic                   release_cycle;

   // Either active-low strobe starts the data phase
   assign strobe = ~RD | ~WR;

   // Decode the latched address; scanning from the top lets the lowest index win
   always_comb begin
      region_t r;
      r       = '0;
      dec_cs  = '0;
      dec_hit = 1'b0;
      dec_ws  = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         r.base = DESC_AW'(REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]);
         r.mask = DESC_AW'(REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]);
         r.io   = REGION_IO[i];
         r.ws   = REGION_WS[i*WS_WIDTH +: WS_WIDTH];
         if (region_match(r, DESC_AW'(addr_q), iom_q)) begin
            dec_cs    = '0;
            dec_cs[i] = 1'b1;
            dec_hit   = 1'b1;
            dec_ws    = r.ws;
         end
      end
   end

   // Bus-cycle state register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and per-cycle control strobes
   always_comb begin
      next_state    = state;
      latch_addr    = 1'b0;
      capture_dec   = 1'b0;
      cnt_load      = 1'b0;
      cnt_dec       = 1'b0;
      ready_clr     = 1'b0;
      ready_set     = 1'b0;
      err_inc       = 1'b0;
      release_cycle = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ALE) begin
               latch_addr = 1'b1;
               next_state = ST_ADDR;
            end
         end
         ST_ADDR: begin
            capture_dec = 1'b1;
            if (strobe) begin
               if (dec_hit && (dec_ws != '0)) begin
                  cnt_load   = 1'b1;
                  ready_clr  = 1'b1;
                  next_state = ST_WAIT;
               end else begin
                  err_inc    = ~dec_hit;
                  next_state = ST_ACTIVE;
               end
            end
         end
         ST_WAIT: begin
            // Counting runs to completion even if the strobe goes away early
            cnt_dec = 1'b1;
            if (cnt_done) begin
               ready_set  = 1'b1;
               next_state = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            // ALE arriving on the release edge is deliberately not captured
            if (RD && WR) begin
               release_cycle = 1'b1;
               next_state    = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Wait-state timer, loaded on the strobe edge of a slow region
   bus_wait_counter #(
      .W (WS_WIDTH)
   ) u_wait_counter (
      .clk        (CLK),
      .reset      (RESET),
      .load       (cnt_load),
      .dec        (cnt_dec),
      .load_value (dec_ws),
      .done       (cnt_done)
   );

   // Address latch, captured only when ALE starts a cycle from IDLE
   always_ff @(posedge CLK) begin
      if (RESET) begin
         addr_q <= '0;
         iom_q  <= 1'b0;
      end else if (latch_addr) begin
         addr_q <= {A, AD};
         iom_q  <= IOM;
      end
   end

   // Registered chip selects and unmapped flag, held until the cycle ends
   always_ff @(posedge CLK) begin
      if (RESET) begin
         cs_q       <= '0;
         unmapped_q <= 1'b0;
      end else if (release_cycle) begin
         cs_q       <= '0;
         unmapped_q <= 1'b0;
      end else if (capture_dec) begin
         cs_q       <= dec_cs;
         unmapped_q <= ~dec_hit;
      end
   end

   // READY drops on the strobe edge of a slow region and returns on the last wait clock
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ready_q <= 1'b1;
      end else if (ready_clr) begin
         ready_q <= 1'b0;
      end else if (ready_set) begin
         ready_q <= 1'b1;
      end
   end

   // Saturating count of accesses that hit no region
   always_ff @(posedge CLK) begin
      if (RESET) begin
         err_q <= '0;
      end else if (err_inc && (err_q != 8'hFF)) begin
         err_q <= err_q + 8'd1;
      end
   end

   assign Address   = addr_q;
   assign CS        = cs_q;
   assign READY     = ready_q;
   assign Unmapped  = unmapped_q;
   assign ErrCount  = err_q;

   // Transceiver enables follow the CPU's DT/R and DEN directly
   assign XcvrToDev = DTR & ~DEN;
   assign XcvrToCpu = ~DTR & ~DEN;

endmodule

// File: tb/tb_bus_region_ctrl.sv
// tb/tb_bus_region_ctrl.sv - randomized self-checking bench for bus_region_ctrl
module tb_bus_region_ctrl;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        ALE;
   logic        IOM;
   logic        RD;
   logic        WR;
   logic        DTR;
   logic        DEN;
   logic [7:0]  AD;
   logic [11:0] A;
   logic [19:0] Address;
   logic [3:0]  CS;
   logic        READY;
   logic        XcvrToDev;
   logic        XcvrToCpu;
   logic        Unmapped;
   logic [7:0]  ErrCount;

   int vectors   = 0;
   int errors    = 0;
   int model_err = 0;

   // Region map of the default 8088 system
   int unsigned ref_base [4] = '{32'h00000, 32'h80000, 32'h0FF00, 32'h01C00};
   int unsigned ref_mask [4] = '{32'h80000, 32'h80000, 32'h0FFF0, 32'h0FE00};
   int          ref_io   [4] = '{0, 0, 1, 1};
   int          ref_ws   [4] = '{0, 2, 1, 3};

   int unsigned addr_pool [10] = '{32'h00123, 32'h80010, 32'h0FF05, 32'h01DFF, 32'h01E00,
                                   32'h01C00, 32'h7FFFF, 32'hFFFFF, 32'h0FF0F, 32'h00000};

   bus_region_ctrl dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .ALE       (ALE),
      .IOM       (IOM),
      .RD        (RD),
      .WR        (WR),
      .DTR       (DTR),
      .DEN       (DEN),
      .AD        (AD),
      .A         (A),
      .Address   (Address),
      .CS        (CS),
      .READY     (READY),
      .XcvrToDev (XcvrToDev),
      .XcvrToCpu (XcvrToCpu),
      .Unmapped  (Unmapped),
      .ErrCount  (ErrCount)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // First region in index order whose rules accept the access
   task automatic ref_decode(input int unsigned addr, input int iom,
                             output logic [3:0] cs, output int ws, output bit unm);
      cs  = 4'b0000;
      ws  = 0;
      unm = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (((addr & ref_mask[i]) == (ref_base[i] & ref_mask[i])) && (iom == ref_io[i])) begin
            cs[i] = 1'b1;
            ws    = ref_ws[i];
            unm   = 1'b0;
            break;
         end
      end
   endtask

   task automatic run_access(input int unsigned addr, input int iom, input bit wr,
                             input int gap, input bit ale_on_release);
      logic [3:0] ecs;
      int         ews;
      bit         eunm;
      int         low;
      logic [19:0] a20;
      a20 = addr[19:0];
      ref_decode(addr, iom, ecs, ews, eunm);
      @(negedge CLK);
      ALE = 1'b1;
      IOM = iom[0];
      A   = a20[19:8];
      AD  = a20[7:0];
      @(posedge CLK);
      #1 check("address", 32'(Address), 32'(a20));
      @(negedge CLK);
      ALE = 1'b0;
      A   = 12'($urandom);
      AD  = 8'($urandom);
      @(posedge CLK);
      #1;
      check("cs_decode", 32'(CS), 32'(ecs));
      check("unmapped", 32'(Unmapped), 32'(eunm));
      check("ready_pre", 32'(READY), 32'd1);
      repeat (gap) @(posedge CLK);
      @(negedge CLK);
      if (wr) WR = 1'b0;
      else    RD = 1'b0;
      if (eunm && model_err < 255) model_err++;
      low = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge CLK);
         #1;
         if (READY === 1'b1) break;
         low++;
      end
      check("ready_low_clocks", 32'(low), 32'(ews));
      check("cs_hold", 32'(CS), 32'(ecs));
      check("err_count", 32'(ErrCount), 32'(model_err));
      @(negedge CLK);
      RD = 1'b1;
      WR = 1'b1;
      if (ale_on_release) begin
         ALE = 1'b1;
         A   = ~a20[19:8];
         AD  = ~a20[7:0];
      end
      @(posedge CLK);
      #1;
      check("cs_release", 32'(CS), 32'd0);
      check("unmapped_release", 32'(Unmapped), 32'd0);
      if (ale_on_release) check("ale_ignored", 32'(Address), 32'(a20));
      @(negedge CLK);
      ALE = 1'b0;
   endtask

   initial begin
      int unsigned ra;
      RESET = 1'b1;
      ALE   = 1'b0;
      IOM   = 1'b0;
      RD    = 1'b1;
      WR    = 1'b1;
      DTR   = 1'b0;
      DEN   = 1'b1;
      AD    = 8'h00;
      A     = 12'h000;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_address", 32'(Address), 32'd0);
      check("rst_cs", 32'(CS), 32'd0);
      check("rst_ready", 32'(READY), 32'd1);
      check("rst_unmapped", 32'(Unmapped), 32'd0);
      check("rst_errcount", 32'(ErrCount), 32'd0);
      @(negedge CLK);
      RESET = 1'b0;

      // Transceiver enables over all DT/R, DEN combinations
      for (int v = 0; v < 4; v++) begin
         @(negedge CLK);
         DTR = v[0];
         DEN = v[1];
         #1;
         check("xcvr_to_dev", 32'(XcvrToDev), 32'(v[0] && !v[1]));
         check("xcvr_to_cpu", 32'(XcvrToCpu), 32'(!v[0] && !v[1]));
      end

      // Directed accesses from the region map
      run_access(32'h00123, 0, 1'b0, 0, 1'b0);
      run_access(32'h80010, 0, 1'b1, 1, 1'b0);
      run_access(32'h0FF05, 1, 1'b0, 0, 1'b0);
      run_access(32'h0FF05, 0, 1'b0, 2, 1'b0);
      run_access(32'h01DFF, 1, 1'b1, 0, 1'b1);
      run_access(32'h01E00, 1, 1'b0, 0, 1'b0);

      // Reset during the wait phase of a three-wait-state access
      @(negedge CLK);
      ALE = 1'b1;
      IOM = 1'b1;
      A   = 12'h01D;
      AD  = 8'h00;
      @(negedge CLK);
      ALE = 1'b0;
      @(negedge CLK);
      WR = 1'b0;
      @(posedge CLK);
      #1 check("wait_ready_low", 32'(READY), 32'd0);
      @(negedge CLK);
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      check("midwait_ready", 32'(READY), 32'd1);
      check("midwait_cs", 32'(CS), 32'd0);
      check("midwait_address", 32'(Address), 32'd0);
      check("midwait_errcount", 32'(ErrCount), 32'd0);
      model_err = 0;
      @(negedge CLK);
      RESET = 1'b0;
      WR    = 1'b1;
      run_access(32'h01C40, 1, 1'b1, 0, 1'b0);

      // Randomized accesses against the reference decode
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 2) == 0) ra = $urandom & 32'hFFFFF;
         else                           ra = addr_pool[$urandom_range(0, 9)];
         run_access(ra, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      // Unmapped I/O accesses until the error count saturates
      for (int t = 0; t < 256; t++) begin
         @(negedge CLK);
         ALE = 1'b1;
         IOM = 1'b1;
         A   = 12'h000;
         AD  = 8'h00;
         @(negedge CLK);
         ALE = 1'b0;
         @(negedge CLK);
         RD = 1'b0;
         if (model_err < 255) model_err++;
         @(negedge CLK);
         RD = 1'b1;
         @(negedge CLK);
      end
      #1 check("err_saturated", 32'(ErrCount), 32'(model_err));
      check("err_saturated_ff", 32'(ErrCount), 32'h000000FF);
      run_access(32'h00000, 1, 1'b0, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
